// File: rtl/tree_pkg.sv
// Shared types and helpers for the scrolling-tree scene.
// Column words are indexed by row: bit r = row r.
package tree_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED,
        DONE
    } state_t;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    function automatic logic [ROWS-1:0] tree_col(
        input logic [3:0] gap_top,
        input int         gap_w
    );
        logic [ROWS-1:0] c;
        int              gt;
        c  = '1;
        gt = int'(gap_top);
        for (int r = 0; r < ROWS; r++) begin
            if (r >= gt && r < gt + gap_w) begin
                c[r] = 1'b0;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tree_scroller_if.sv
// Control and scene bus between the game controller and the tree scroller.
// The controller is master; the scroller is slave.
interface tree_scroller_if;
    import tree_pkg::*;

    logic                       start;
    logic                       halt;
    logic [ROWS-1:0][COLS-1:0]  grn_array;
    logic [ROWS-1:0]            g1;
    logic                       treespass;
    logic                       busy;

    modport master (
        output start,
        output halt,
        input  grn_array,
        input  g1,
        input  treespass,
        input  busy
    );

    modport slave (
        input  start,
        input  halt,
        output grn_array,
        output g1,
        output treespass,
        output busy
    );

endinterface

// File: rtl/gap_lfsr.sv
// 4-bit Fibonacci LFSR (x^4+x^3+1) choosing tree gap positions.
// Seeded with 4'b1001, so the all-zero lock-up state is never entered.
module gap_lfsr (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       adv,
    output logic [3:0] lfsr
);

    logic [3:0] lfsr_q;
    logic [3:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 4'b1001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/tree_scroller.sv
// Scrolling tree generator: shifts a 16x16 scene left once per tick,
// spawns gapped trees, and counts trees that have passed the bird column.
module tree_scroller
    import tree_pkg::*;
#(
    parameter int STEP_W     = 10,
    parameter int TREE_SPACE = 6,
    parameter int NUM_TREES  = 8,
    parameter int GAP_W      = 3,
    parameter int BIRD_COL   = 3
) (
    input  logic           clock,
    input  logic           reset_n,
    tree_scroller_if.slave bus
);

    localparam int SP_W  = $clog2(TREE_SPACE);
    localparam int CNT_W = $clog2(NUM_TREES + 1);
    localparam logic [CNT_W-1:0] NT      = CNT_W'(NUM_TREES);
    localparam logic [SP_W-1:0]  SP_LAST = SP_W'(TREE_SPACE - 1);

    state_t                    state_q, state_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic [SP_W-1:0]           spawn_q, spawn_d;
    logic [CNT_W-1:0]          emitted_q, emitted_d;
    logic [CNT_W-1:0]          passed_q, passed_d;
    logic [COLS-1:0][ROWS-1:0] cols_q, cols_d;

    logic                      tick;
    logic                      spawning;
    logic [3:0]                lfsr;
    logic [3:0]                gap_top;
    logic [ROWS-1:0]           new_col;
    logic [ROWS-1:0]           g1;
    logic [ROWS-1:0][COLS-1:0] grn;

    gap_lfsr u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .adv     (tick),
        .lfsr    (lfsr)
    );

    assign tick     = (state_q == RUN) && (step_q == '1);
    assign spawning = (spawn_q == '0) && (emitted_q < NT);
    assign gap_top  = (int'(lfsr) <= ROWS - GAP_W) ? lfsr
                                                    : lfsr - 4'(GAP_W);
    assign new_col  = spawning ? tree_col(gap_top, GAP_W) : '0;
    assign g1       = cols_q[BIRD_COL];

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        spawn_d   = spawn_q;
        emitted_d = emitted_q;
        passed_d  = passed_q;
        cols_d    = cols_q;
        unique case (state_q)
            IDLE, HALTED, DONE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    step_d    = '0;
                    spawn_d   = '0;
                    emitted_d = '0;
                    passed_d  = '0;
                    cols_d    = '0;
                end
            end
            RUN: begin
                step_d = step_q + 1'b1;
                if (tick) begin
                    // col 0 falls off; new column enters on the right
                    cols_d  = {new_col, cols_q[COLS-1:1]};
                    spawn_d = (spawn_q == SP_LAST) ? '0 : spawn_q + 1'b1;
                    if (spawning) begin
                        emitted_d = emitted_q + 1'b1;
                    end
                    if (g1 != '0 && passed_q != NT) begin
                        passed_d = passed_q + 1'b1;
                    end
                end
                if (bus.halt) begin
                    state_d = HALTED;
                end else if (passed_q == NT) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            spawn_q   <= '0;
            emitted_q <= '0;
            passed_q  <= '0;
            cols_q    <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            spawn_q   <= spawn_d;
            emitted_q <= emitted_d;
            passed_q  <= passed_d;
            cols_q    <= cols_d;
        end
    end

    always_comb begin
        grn = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                grn[r][c] = cols_q[c][r];
            end
        end
    end

    assign bus.grn_array = grn;
    assign bus.g1        = g1;
    assign bus.treespass = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_tree_scroller.sv
// Directed scoreboard bench for tree_scroller (tick every 4 clocks,
// two trees per game, gap of 3 rows, bird at column 3).
module tb_tree_scroller;
    import tree_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    tree_scroller_if bus ();

    tree_scroller #(
        .STEP_W     (2),
        .TREE_SPACE (6),
        .NUM_TREES  (2),
        .GAP_W      (3),
        .BIRD_COL   (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        string       name;
        logic [15:0] g1;
        logic        tp;
        logic        busy;
        int          col;
        logic [15:0] colv;
        bit          allz;
    } exp_t;

    exp_t q[$];
    event smp_ev;
    int   checks = 0;
    int   errors = 0;
    int   cur    = 0;

    task automatic exp_push(input string n, input logic [15:0] g,
                            input logic tp, input logic b, input int c,
                            input logic [15:0] cv, input bit z);
        exp_t e;
        e.name = n;
        e.g1   = g;
        e.tp   = tp;
        e.busy = b;
        e.col  = c;
        e.colv = cv;
        e.allz = z;
        q.push_back(e);
        ->smp_ev;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        cur += n;
    endtask

    task automatic to_cyc(input int m);
        cyc(m - cur);
    endtask

    // Start edge lies between this negedge and the next; cur 0 is the next.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        cur = 0;
    endtask

    initial begin
        forever begin
            @(smp_ev);
            while (q.size() > 0) begin
                exp_t        e;
                logic [15:0] cv;
                bit          ok;
                e  = q.pop_front();
                cv = '0;
                if (e.col >= 0) begin
                    for (int r = 0; r < 16; r++) begin
                        cv[r] = bus.grn_array[r][e.col];
                    end
                end
                ok = (bus.g1 === e.g1) && (bus.treespass === e.tp)
                     && (bus.busy === e.busy);
                if (e.col >= 0) ok = ok && (cv === e.colv);
                if (e.allz) ok = ok && (bus.grn_array === '0);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got g1=%h tp=%b busy=%b col%0d=%h nz=%b want g1=%h tp=%b busy=%b col=%h allz=%b",
                             e.name, bus.g1, bus.treespass, bus.busy, e.col,
                             cv, |bus.grn_array, e.g1, e.tp, e.busy,
                             e.colv, e.allz);
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.halt  = 1'b0;
        #1;
        exp_push("reset", 16'h0, 0, 0, -1, 16'h0, 1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // reset while a game is running
        pulse_start();
        exp_push("start_busy", 16'h0, 0, 1, 15, 16'h0, 0);
        to_cyc(14);
        exp_push("pre_reset_col13", 16'h0, 0, 1, 13, 16'hF1FF, 0);
        reset_n = 1'b0;
        #1;
        exp_push("reset_mid", 16'h0, 0, 0, -1, 16'h0, 1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        exp_push("idle20", 16'h0, 0, 0, -1, 16'h0, 1);

        // game A: gaps at L=9 and L=11
        pulse_start();
        to_cyc(4);
        exp_push("a_tick1_col15", 16'h0, 0, 1, 15, 16'hF1FF, 0);
        to_cyc(52);
        exp_push("a_tick13_g1", 16'hF1FF, 0, 1, 15, 16'h0, 0);
        to_cyc(56);
        exp_push("a_tick14_g1", 16'h0, 0, 1, 4, 16'h0, 0);
        to_cyc(76);
        exp_push("a_tick19_g1", 16'hC7FF, 0, 1, 15, 16'h0, 0);
        to_cyc(80);
        exp_push("a_tick20", 16'h0, 0, 1, 2, 16'hC7FF, 0);
        to_cyc(81);
        exp_push("a_done", 16'h0, 1, 0, 2, 16'hC7FF, 0);
        to_cyc(101);
        exp_push("a_frozen", 16'h0, 1, 0, 2, 16'hC7FF, 0);

        // game B: gaps at L=5 and L=8, halted with tree at bird
        pulse_start();
        to_cyc(4);
        exp_push("b_tick1_col15", 16'h0, 0, 1, 15, 16'hFF1F, 0);
        to_cyc(52);
        exp_push("b_tick13_g1", 16'hFF1F, 0, 1, 9, 16'hF8FF, 0);
        bus.halt = 1'b1;
        cyc(1);
        exp_push("b_halted", 16'hFF1F, 0, 0, 9, 16'hF8FF, 0);
        cyc(50);
        exp_push("b_halt50", 16'hFF1F, 0, 0, 9, 16'hF8FF, 0);
        bus.halt = 1'b0;

        // game C: gap boundary L=13, wrap L=14; halt on final pass tick
        pulse_start();
        to_cyc(4);
        exp_push("c_gap13", 16'h0, 0, 1, 15, 16'h1FFF, 0);
        to_cyc(28);
        exp_push("c_gap14", 16'h0, 0, 1, 15, 16'hC7FF, 0);
        to_cyc(79);
        bus.halt = 1'b1;
        cyc(1);
        exp_push("c_halt_final", 16'h0, 0, 0, 2, 16'hC7FF, 0);
        bus.halt = 1'b0;
        cyc(1);
        exp_push("c_stay_halted", 16'h0, 0, 0, 2, 16'hC7FF, 0);
        pulse_start();
        exp_push("c_restart_clear", 16'h0, 0, 1, 2, 16'h0, 1);
        cyc(2);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
